// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle around axis_rr_arbiter: n_in producer streams in, one merged stream out.
// The arbiter takes the slave view; producers and the sink together take the master view.
interface axis_rr_arbiter_if #(
   parameter int n_in = 4,
   parameter int nb   = 40,
   parameter int idw  = $clog2(n_in)
);
   logic [n_in*nb-1:0] in_tdata;
   logic [n_in-1:0]    in_tvalid;
   logic [n_in-1:0]    in_tlast;
   logic [n_in-1:0]    in_tready;
   logic [nb-1:0]      out_tdata;
   logic               out_tlast;
   logic [idw-1:0]     out_tid;
   logic               out_tvalid;
   logic               out_tready;

   modport slave (
      input  in_tdata, in_tvalid, in_tlast, out_tready,
      output in_tready, out_tdata, out_tlast, out_tid, out_tvalid
   );

   modport master (
      output in_tdata, in_tvalid, in_tlast, out_tready,
      input  in_tready, out_tdata, out_tlast, out_tid, out_tvalid
   );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-locked round-robin merge of n_in AXI-Stream sources into one sink.
// Output is fed from a two-entry skid stage so every ready/valid output is a flop.
module axis_rr_arbiter #(
   parameter int n_in = 4,
   parameter int n    = 5,
   parameter int nb   = n*8,
   parameter int idw  = $clog2(n_in)
) (
   input logic              aclk,
   input logic              aresetn,
   axis_rr_arbiter_if.slave bus
);
   localparam logic [0:0]     IDLE     = 1'b0;
   localparam logic [0:0]     LOCK     = 1'b1;
   localparam logic [idw-1:0] LAST_RST = idw'(n_in - 1);

   typedef struct packed {
      logic [nb-1:0]  data;
      logic           last;
      logic [idw-1:0] tid;
   } beat_t;

   logic [0:0]      state_q, state_d;
   logic [idw-1:0]  g_q, g_d;
   logic [idw-1:0]  last_q, last_d;
   logic [n_in-1:0] in_tready_q, in_tready_d;
   logic [1:0]      count_q, count_d;
   logic            valid_q, valid_d;
   beat_t           head_q, head_d;
   beat_t           tail_q, tail_d;

   logic            found;
   logic [idw-1:0]  pick;
   logic [idw-1:0]  cand;
   logic            push;
   logic            pop;
   beat_t           in_beat;

   // Search last+1, last+2, ... with wrap; the first requester found wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      found = 1'b0;
      pick  = last_q;
      cand  = last_q;
      for (int i = 1; i <= n_in; i++) begin
         cand = idw'((int'(last_q) + i) % n_in);
         if (!found && bus.in_tvalid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      in_beat      = '0;
      in_beat.last = bus.in_tlast[g_q];
      in_beat.tid  = g_q;
      for (int k = 0; k < n_in; k++) begin
         if (g_q == idw'(k)) in_beat.data = bus.in_tdata[k*nb +: nb];
      end
   end

   assign push = (state_q == LOCK) & bus.in_tvalid[g_q] & in_tready_q[g_q];
   assign pop  = valid_q & bus.out_tready;

   // Shift-style skid stage: head always drives the output, tail only holds the overflow beat.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = in_beat;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = in_beat;
            end else if (push) begin
               tail_d  = in_beat;
               count_d = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_d  = tail_q;
               count_d = 2'd1;
            end
         end
      endcase
      valid_d = (count_d != 2'd0);
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = LOCK;
               g_d     = pick;
               last_d  = pick;
            end
         end
         default: begin
            if (push && in_beat.last) state_d = IDLE;
         end
      endcase
      // Ready is computed from next state so the flop already reflects the new grant and fill level.
      in_tready_d = '0;
      if (state_d == LOCK && count_d != 2'd2) in_tready_d[g_d] = 1'b1;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q     <= IDLE;
         g_q         <= '0;
         last_q      <= LAST_RST;
         in_tready_q <= '0;
         count_q     <= 2'd0;
         valid_q     <= 1'b0;
         // NOTE: both skid entries are reset so out_* reads zero right after reset, never stale beats.
         head_q      <= '0;
         tail_q      <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         g_q         <= g_d;
         last_q      <= last_d;
         in_tready_q <= in_tready_d;
         count_q     <= count_d;
         valid_q     <= valid_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
      end
   end

   assign bus.in_tready  = in_tready_q;
   assign bus.out_tvalid = valid_q;
   assign bus.out_tdata  = head_q.data;
   assign bus.out_tlast  = head_q.last;
   assign bus.out_tid    = head_q.tid;
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: reset, fairness, packet lock, backpressure,
// mid-packet reset and a short random run checked against per-source expectations.
module tb_axis_rr_arbiter;
   localparam int N_IN = 4;
   localparam int N    = 5;
   localparam int NB   = N*8;
   localparam int IDW  = 2;

   logic        aclk;
   logic        aresetn;
   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   bit          rnd_mode = 1'b0;

   axis_rr_arbiter_if #(.n_in(N_IN), .nb(NB), .idw(IDW)) bus ();

   axis_rr_arbiter #(.n_in(N_IN), .n(N)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      logic [IDW-1:0] tid;
      logic [NB-1:0]  data;
      logic           last;
      int unsigned    t;
   } obs_t;

   obs_t mon_q[$];

   // Record every beat the sink will consume on the coming edge.
   always @(negedge aclk)
      if (aresetn === 1'b1 && bus.out_tvalid === 1'b1 && bus.out_tready === 1'b1)
         mon_q.push_back('{tid: bus.out_tid, data: bus.out_tdata, last: bus.out_tlast, t: cyc});

   logic [NB-1:0] sq_data [N_IN][$];
   logic          sq_last [N_IN][$];
   bit            src_en  [N_IN];
   logic [NB-1:0] ed      [N_IN][$];
   logic          el      [N_IN][$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N_IN; k++) begin
         if (src_en[k] && sq_data[k].size() > 0) begin
            bus.in_tvalid[k]          = 1'b1;
            bus.in_tdata[k*NB +: NB]  = sq_data[k][0];
            bus.in_tlast[k]           = sq_last[k][0];
         end else begin
            bus.in_tvalid[k]          = 1'b0;
            bus.in_tdata[k*NB +: NB]  = '0;
            bus.in_tlast[k]           = 1'b0;
         end
      end
   endtask

   task automatic step();
      bit fire [N_IN];
      @(negedge aclk);
      for (int k = 0; k < N_IN; k++)
         fire[k] = (aresetn === 1'b1) && bus.in_tvalid[k] && (bus.in_tready[k] === 1'b1);
      @(posedge aclk);
      #1;
      for (int k = 0; k < N_IN; k++) begin
         if (fire[k]) begin
            sq_data[k].delete(0);
            sq_last[k].delete(0);
         end
      end
      if (rnd_mode) begin
         bus.out_tready = 1'($urandom_range(0, 1));
         for (int k = 0; k < N_IN; k++) src_en[k] = ($urandom_range(0, 3) != 0);
      end
      drive();
   endtask

   task automatic add_pkt(input int k, input int len, input logic [NB-1:0] base);
      for (int b = 0; b < len; b++) begin
         sq_data[k].push_back(base + NB'(b));
         sq_last[k].push_back(b == len - 1);
         ed[k].push_back(base + NB'(b));
         el[k].push_back(b == len - 1);
      end
   endtask

   task automatic wait_out(input string tag, input int cnt, input int budget);
      for (int i = 0; i < budget && mon_q.size() < cnt; i++) step();
      check({tag, " beat count"}, 64'(mon_q.size()), 64'(cnt));
   endtask

   task automatic check_beat(input string tag, input int j, input int tid,
                             input logic [NB-1:0] data, input logic last);
      if (j < mon_q.size()) begin
         check({tag, " tid"},  64'(mon_q[j].tid),  64'(tid));
         check({tag, " data"}, 64'(mon_q[j].data), 64'(data));
         check({tag, " last"}, 64'(mon_q[j].last), 64'(last));
      end
   endtask

   initial begin
      int            ep, ek, eb, total, t, cur;
      bit            in_pkt;

      aresetn        = 1'b0;
      bus.out_tready = 1'b0;
      for (int k = 0; k < N_IN; k++) src_en[k] = 1'b0;
      drive();

      // Reset values, then ten quiet cycles with nothing requesting.
      repeat (2) step();
      check("rst out_tvalid", 64'(bus.out_tvalid), 64'h0);
      check("rst out_tdata",  64'(bus.out_tdata),  64'h0);
      check("rst out_tlast",  64'(bus.out_tlast),  64'h0);
      check("rst out_tid",    64'(bus.out_tid),    64'h0);
      check("rst in_tready",  64'(bus.in_tready),  64'h0);
      aresetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle in_tready",  64'(bus.in_tready),  64'h0);
         check("idle out_tvalid", 64'(bus.out_tvalid), 64'h0);
      end

      // Round robin: every source offers two 3-beat packets; source 0 goes first.
      mon_q.delete();
      for (int p = 0; p < 2; p++)
         for (int k = 0; k < N_IN; k++) add_pkt(k, 3, NB'((k << 8) | (p << 4)));
      for (int k = 0; k < N_IN; k++) src_en[k] = 1'b1;
      bus.out_tready = 1'b1;
      drive();
      wait_out("rr", 24, 120);
      for (int j = 0; j < 24; j++) begin
         ep = j / 12;
         ek = (j % 12) / 3;
         eb = j % 3;
         check_beat("rr", j, ek, NB'((ek << 8) | (ep << 4) | eb), eb == 2);
         if (j > 0 && j < mon_q.size())
            check("rr spacing", 64'(mon_q[j].t - mon_q[j-1].t), (eb == 0) ? 64'd2 : 64'd1);
      end
      for (int k = 0; k < N_IN; k++) src_en[k] = 1'b0;
      drive();
      repeat (3) step();

      // Packet lock: source 1 stalls mid-packet while source 2 keeps requesting.
      mon_q.delete();
      add_pkt(1, 2, NB'(40'hA0));
      add_pkt(2, 2, NB'(40'hC0));
      src_en[1] = 1'b1;
      src_en[2] = 1'b1;
      drive();
      for (int i = 0; i < 20 && sq_data[1].size() != 1; i++) step();
      check("lock first beat taken", 64'(sq_data[1].size()), 64'd1);
      src_en[1] = 1'b0;
      drive();
      for (int i = 0; i < 5; i++) begin
         step();
         check("lock gap in_tready", 64'(bus.in_tready), 64'h2);
      end
      src_en[1] = 1'b1;
      drive();
      wait_out("lock", 4, 30);
      check_beat("lock A",  0, 1, NB'(40'hA0), 1'b0);
      check_beat("lock B",  1, 1, NB'(40'hA1), 1'b1);
      check_beat("lock C0", 2, 2, NB'(40'hC0), 1'b0);
      check_beat("lock C1", 3, 2, NB'(40'hC1), 1'b1);
      src_en[1] = 1'b0;
      src_en[2] = 1'b0;
      drive();
      repeat (3) step();

      // Backpressure: sink stalled, source 0 streams 0x01..0x05.
      mon_q.delete();
      bus.out_tready = 1'b0;
      add_pkt(0, 5, NB'(40'h01));
      src_en[0] = 1'b1;
      drive();
      step();
      check("bp grant in_tready", 64'(bus.in_tready),  64'h1);
      check("bp grant out_tvalid", 64'(bus.out_tvalid), 64'h0);
      step();
      check("bp 1st accept in_tready", 64'(bus.in_tready),  64'h1);
      check("bp 1st accept out_tvalid", 64'(bus.out_tvalid), 64'h1);
      check("bp 1st accept out_tdata", 64'(bus.out_tdata),  64'h01);
      step();
      check("bp full in_tready", 64'(bus.in_tready), 64'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp stall in_tready",  64'(bus.in_tready),  64'h0);
         check("bp stall out_tvalid", 64'(bus.out_tvalid), 64'h1);
         check("bp stall out_tdata",  64'(bus.out_tdata),  64'h01);
      end
      bus.out_tready = 1'b1;
      step();
      check("bp read in_tready", 64'(bus.in_tready), 64'h1);
      check("bp read out_tdata", 64'(bus.out_tdata), 64'h02);
      wait_out("bp", 5, 40);
      repeat (4) step();
      check("bp no duplicates", 64'(mon_q.size()), 64'd5);
      for (int j = 0; j < 5; j++) check_beat("bp", j, 0, NB'(j + 1), j == 4);
      src_en[0] = 1'b0;
      drive();
      repeat (2) step();

      // Reset in the middle of a 4-beat packet from source 3 with one beat held.
      mon_q.delete();
      add_pkt(3, 4, NB'(40'hD0));
      src_en[3] = 1'b1;
      drive();
      for (int i = 0; i < 20 && sq_data[3].size() != 2; i++) step();
      check("mrst two beats taken", 64'(sq_data[3].size()), 64'd2);
      check("mrst half full tvalid", 64'(bus.out_tvalid), 64'h1);
      check("mrst half full tdata",  64'(bus.out_tdata),  64'hD1);
      check("mrst half full tid",    64'(bus.out_tid),    64'h3);
      aresetn = 1'b0;
      step();
      check("mrst out_tvalid", 64'(bus.out_tvalid), 64'h0);
      check("mrst in_tready",  64'(bus.in_tready),  64'h0);
      check("mrst out_tid",    64'(bus.out_tid),    64'h0);
      aresetn = 1'b1;
      sq_data[3].delete();
      sq_last[3].delete();
      mon_q.delete();
      add_pkt(1, 2, NB'(40'hE0));
      add_pkt(3, 1, NB'(40'hF0));
      src_en[1] = 1'b1;
      drive();
      step();
      check("mrst regrant in_tready", 64'(bus.in_tready), 64'h2);
      wait_out("mrst", 3, 30);
      check_beat("mrst E0", 0, 1, NB'(40'hE0), 1'b0);
      check_beat("mrst E1", 1, 1, NB'(40'hE1), 1'b1);
      check_beat("mrst F0", 2, 3, NB'(40'hF0), 1'b1);
      for (int k = 0; k < N_IN; k++) src_en[k] = 1'b0;
      drive();
      repeat (3) step();

      // Random valid/ready: each source's packets must arrive intact and unbroken.
      mon_q.delete();
      total = 0;
      for (int k = 0; k < N_IN; k++) begin
         ed[k].delete();
         el[k].delete();
      end
      for (int p = 0; p < 3; p++) begin
         for (int k = 0; k < N_IN; k++) begin
            eb = int'($urandom_range(1, 4));
            add_pkt(k, eb, NB'((k << 12) | (p << 4)));
            total += eb;
         end
      end
      rnd_mode = 1'b1;
      wait_out("rand", total, 3000);
      rnd_mode = 1'b0;
      bus.out_tready = 1'b1;
      for (int k = 0; k < N_IN; k++) src_en[k] = 1'b0;
      drive();
      in_pkt = 1'b0;
      cur    = 0;
      for (int j = 0; j < mon_q.size(); j++) begin
         t = int'(mon_q[j].tid);
         if (in_pkt) check("rand contiguous tid", 64'(t), 64'(cur));
         check("rand source has pending beat", 64'(ed[t].size() != 0), 64'h1);
         if (ed[t].size() != 0) begin
            check("rand data", 64'(mon_q[j].data), 64'(ed[t][0]));
            check("rand last", 64'(mon_q[j].last), 64'(el[t][0]));
            ed[t].delete(0);
            el[t].delete(0);
         end
         cur    = t;
         in_pkt = !mon_q[j].last;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
